// File: rtl/vc_fifo_pkg.sv
// -----------------------------------------------------------------------------
// vc_fifo_pkg
// Shared definitions for the virtual-channel FIFO and the router blocks that
// sit around it:
//   DEFAULT_WIDTH  default flit width used by the router datapath
//   min1_clog2()   ceil(log2(n)) clamped to at least 1, used for the VC index
//                  width and for the shared storage address width
// Optional feature macro used by this slice: VC_FIFO_ERR_EN (see vc_fifo.sv).
// -----------------------------------------------------------------------------
package vc_fifo_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // A single VC still needs a one-bit select so the port never collapses to
    // zero width.
    function automatic int min1_clog2(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/vc_fifo_if.sv
// -----------------------------------------------------------------------------
// vc_fifo_if
// Link-side / allocator-side bundle of the virtual-channel FIFO.
//   master : drives write, wr_vc, item_in, read, rd_vc; observes status/data
//   slave  : the FIFO itself; drives item_out, valid_out, full, empty,
//            almost_full (plus overflow/underflow when VC_FIFO_ERR_EN is set)
// Parameters WIDTH and NUM_VC must match the vc_fifo instance it is bound to.
// -----------------------------------------------------------------------------
interface vc_fifo_if #(
    parameter int WIDTH  = vc_fifo_pkg::DEFAULT_WIDTH,
    parameter int NUM_VC = 2
) ();
    localparam int VC_W = vc_fifo_pkg::min1_clog2(NUM_VC);

    logic              write;
    logic [VC_W-1:0]   wr_vc;
    logic [WIDTH-1:0]  item_in;
    logic              read;
    logic [VC_W-1:0]   rd_vc;
    logic [WIDTH-1:0]  item_out;
    logic              valid_out;
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] empty;
    logic [NUM_VC-1:0] almost_full;
`ifdef VC_FIFO_ERR_EN
    logic [NUM_VC-1:0] overflow;
    logic [NUM_VC-1:0] underflow;

    modport master (
        output write, wr_vc, item_in, read, rd_vc,
        input  item_out, valid_out, full, empty, almost_full, overflow, underflow
    );
    modport slave (
        input  write, wr_vc, item_in, read, rd_vc,
        output item_out, valid_out, full, empty, almost_full, overflow, underflow
    );
`else
    modport master (
        output write, wr_vc, item_in, read, rd_vc,
        input  item_out, valid_out, full, empty, almost_full
    );
    modport slave (
        input  write, wr_vc, item_in, read, rd_vc,
        output item_out, valid_out, full, empty, almost_full
    );
`endif

endinterface

// File: rtl/vc_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// vc_fifo_ctrl
// Pointer pair and status generation for one virtual channel.
//   clk, reset      clock, asynchronous active-high reset
//   wr_en, rd_en    already-qualified (accepted) write / read for this VC
//   wptr, rptr      registered pointers, DEPTH-wrapping with one extra MSB
//   full, empty     derived from the pointers only
//   almost_full     occupancy (wptr - rptr, modulo 2*DEPTH) >= AF_LEVEL
// -----------------------------------------------------------------------------
module vc_fifo_ctrl #(
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int PW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic [PW-1:0] wptr,
    output logic [PW-1:0] rptr,
    output logic          full,
    output logic          empty,
    output logic          almost_full
);

    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic [PW-1:0] occ_s;

    // Pointer advance on accepted requests; the extra MSB separates full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (wr_en) begin
                wptr_r <= wptr_r + PW'(1'b1);
            end
            if (rd_en) begin
                rptr_r <= rptr_r + PW'(1'b1);
            end
        end
    end

    // PW-bit subtraction is exactly occupancy modulo 2*DEPTH.
    assign occ_s       = wptr_r - rptr_r;
    assign full        = (wptr_r[PW-1] != rptr_r[PW-1]) &&
                         (wptr_r[PW-2:0] == rptr_r[PW-2:0]);
    assign empty       = (wptr_r == rptr_r);
    assign almost_full = (occ_s >= PW'(AF_LEVEL));
    assign wptr        = wptr_r;
    assign rptr        = rptr_r;

endmodule

// File: rtl/vc_fifo.sv
// -----------------------------------------------------------------------------
// vc_fifo
// Single-clock multi-channel FIFO for a NoC router input port. NUM_VC queues,
// each DEPTH x WIDTH, share one storage array addressed as vc*DEPTH + ptr.
//   clk, reset  clock, asynchronous active-high reset (storage not cleared)
//   bus         vc_fifo_if.slave: write/wr_vc/item_in, read/rd_vc,
//               item_out (registered, 1-cycle latency), valid_out,
//               full/empty/almost_full per VC
// Optional: define VC_FIFO_ERR_EN to add per-VC sticky overflow (dropped
// write) and underflow (ignored read) flags, cleared only by reset.
// -----------------------------------------------------------------------------
module vc_fifo
    import vc_fifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = 4,
    parameter int NUM_VC   = 2,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input logic      clk,
    input logic      reset,
    vc_fifo_if.slave bus
);

    localparam int VC_W    = min1_clog2(NUM_VC);
    localparam int PW      = $clog2(DEPTH) + 1;
    localparam int ENTRIES = NUM_VC * DEPTH;
    localparam int AW      = min1_clog2(ENTRIES);

    logic [WIDTH-1:0]  mem_r [ENTRIES];
    logic [PW-1:0]     wptr_s [NUM_VC];
    logic [PW-1:0]     rptr_s [NUM_VC];
    logic [NUM_VC-1:0] wr_sel_s;
    logic [NUM_VC-1:0] rd_sel_s;
    logic [NUM_VC-1:0] wr_acc_s;
    logic [NUM_VC-1:0] rd_acc_s;
    logic [NUM_VC-1:0] full_s;
    logic [NUM_VC-1:0] empty_s;
    logic [NUM_VC-1:0] af_s;
    logic [AW-1:0]     wr_addr_s;
    logic [AW-1:0]     rd_addr_s;
    logic [WIDTH-1:0]  item_out_r;
    logic              valid_out_r;

    // Per-VC decode: an out-of-range VC index matches no channel and is
    // therefore ignored without touching any state.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign wr_sel_s[v] = bus.write & (bus.wr_vc == VC_W'(v));
        assign rd_sel_s[v] = bus.read  & (bus.rd_vc == VC_W'(v));
        // Full/empty are the pre-edge values, so a same-VC write to a full
        // queue is dropped even when a read frees a slot at the same edge.
        assign wr_acc_s[v] = wr_sel_s[v] & ~full_s[v];
        assign rd_acc_s[v] = rd_sel_s[v] & ~empty_s[v];

        vc_fifo_ctrl #(
            .DEPTH    (DEPTH),
            .AF_LEVEL (AF_LEVEL),
            .PW       (PW)
        ) u_ctrl (
            .clk         (clk),
            .reset       (reset),
            .wr_en       (wr_acc_s[v]),
            .rd_en       (rd_acc_s[v]),
            .wptr        (wptr_s[v]),
            .rptr        (rptr_s[v]),
            .full        (full_s[v]),
            .empty       (empty_s[v]),
            .almost_full (af_s[v])
        );
    end

    // Storage address mux: at most one VC is selected for each direction.
    always_comb begin
        wr_addr_s = '0;
        rd_addr_s = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_addr_s = wr_acc_s[v] ? (AW'(v * DEPTH) + AW'(wptr_s[v][PW-2:0])) : wr_addr_s;
            rd_addr_s = rd_acc_s[v] ? (AW'(v * DEPTH) + AW'(rptr_s[v][PW-2:0])) : rd_addr_s;
        end
    end

    // Shared storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (|wr_acc_s) begin
            mem_r[wr_addr_s] <= bus.item_in;
        end
    end

    // Registered read port: head entry captured on an accepted read, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            item_out_r  <= '0;
            valid_out_r <= 1'b0;
        end else begin
            valid_out_r <= |rd_acc_s;
            if (|rd_acc_s) begin
                item_out_r <= mem_r[rd_addr_s];
            end
        end
    end

    assign bus.item_out    = item_out_r;
    assign bus.valid_out   = valid_out_r;
    assign bus.full        = full_s;
    assign bus.empty       = empty_s;
    assign bus.almost_full = af_s;

`ifdef VC_FIFO_ERR_EN
    logic [NUM_VC-1:0] overflow_r;
    logic [NUM_VC-1:0] underflow_r;

    // Sticky error capture for rejected requests to a valid VC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r  <= '0;
            underflow_r <= '0;
        end else begin
            overflow_r  <= overflow_r  | (wr_sel_s & full_s);
            underflow_r <= underflow_r | (rd_sel_s & empty_s);
        end
    end

    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
`endif

endmodule

// File: tb/tb_vc_fifo.sv
module tb_vc_fifo;

    localparam int WIDTH    = 4;
    localparam int DEPTH    = 4;
    localparam int NUM_VC   = 2;
    localparam int AF_LEVEL = 3;
    localparam int VC_W     = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference model: one plain queue per VC plus the expected output regs.
    logic [WIDTH-1:0]  model_q [NUM_VC][$];
    logic [WIDTH-1:0]  exp_item;
    logic              exp_valid;
    logic [NUM_VC-1:0] exp_ovf;
    logic [NUM_VC-1:0] exp_udf;

    vc_fifo_if #(.WIDTH(WIDTH), .NUM_VC(NUM_VC)) bus ();

    vc_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NUM_VC   (NUM_VC),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_VC-1:0] exp_full();
        logic [NUM_VC-1:0] f;
        for (int v = 0; v < NUM_VC; v++) f[v] = (model_q[v].size() == DEPTH);
        return f;
    endfunction

    function automatic logic [NUM_VC-1:0] exp_empty();
        logic [NUM_VC-1:0] f;
        for (int v = 0; v < NUM_VC; v++) f[v] = (model_q[v].size() == 0);
        return f;
    endfunction

    function automatic logic [NUM_VC-1:0] exp_af();
        logic [NUM_VC-1:0] f;
        for (int v = 0; v < NUM_VC; v++) f[v] = (model_q[v].size() >= AF_LEVEL);
        return f;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NUM_VC; v++) model_q[v].delete();
        exp_item  = '0;
        exp_valid = 1'b0;
        exp_ovf   = '0;
        exp_udf   = '0;
    endtask

    task automatic idle_inputs();
        bus.write   = 1'b0;
        bus.wr_vc   = '0;
        bus.item_in = '0;
        bus.read    = 1'b0;
        bus.rd_vc   = '0;
    endtask

    // Apply one cycle of requests, advance the model, return 1 time unit after the edge.
    task automatic drive_step(input logic w, input int wvc, input logic [WIDTH-1:0] d,
                              input logic r, input int rvc);
        bit wacc;
        bit racc;
        @(negedge clk);
        bus.write   = w;
        bus.wr_vc   = VC_W'(wvc);
        bus.item_in = d;
        bus.read    = r;
        bus.rd_vc   = VC_W'(rvc);
        wacc = 1'b0;
        racc = 1'b0;
        if (w && wvc < NUM_VC) begin
            wacc = (model_q[wvc].size() < DEPTH);
            if (!wacc) exp_ovf[wvc] = 1'b1;
        end
        if (r && rvc < NUM_VC) begin
            racc = (model_q[rvc].size() > 0);
            if (!racc) exp_udf[rvc] = 1'b1;
        end
        if (racc) exp_item = model_q[rvc].pop_front();
        exp_valid = racc;
        if (wacc) model_q[wvc].push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #3;
        n_vec++; if (bus.empty !== 2'b11) begin n_fail++; $display("FAIL reset_empty: got %b want %b", bus.empty, 2'b11); end
        n_vec++; if (bus.full !== 2'b00) begin n_fail++; $display("FAIL reset_full: got %b want %b", bus.full, 2'b00); end
        n_vec++; if (bus.almost_full !== 2'b00) begin n_fail++; $display("FAIL reset_af: got %b want %b", bus.almost_full, 2'b00); end
        n_vec++; if (bus.item_out !== 4'h0) begin n_fail++; $display("FAIL reset_item: got %h want %h", bus.item_out, 4'h0); end
        n_vec++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want %b", bus.valid_out, 1'b0); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fill_vc0();
        for (int i = 1; i <= 4; i++) begin
            drive_step(1'b1, 0, WIDTH'(i), 1'b0, 0);
            n_vec++; if (bus.full !== exp_full()) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus.full, exp_full()); end
            n_vec++; if (bus.empty !== exp_empty()) begin n_fail++; $display("FAIL fill_empty[%0d]: got %b want %b", i, bus.empty, exp_empty()); end
            n_vec++; if (bus.almost_full !== exp_af()) begin n_fail++; $display("FAIL fill_af[%0d]: got %b want %b", i, bus.almost_full, exp_af()); end
        end
        n_vec++; if (bus.empty !== 2'b10) begin n_fail++; $display("FAIL fill_empty_final: got %b want %b", bus.empty, 2'b10); end
        n_vec++; if (bus.full !== 2'b01) begin n_fail++; $display("FAIL fill_full_final: got %b want %b", bus.full, 2'b01); end
    endtask

    task automatic test_drain_vc0();
        for (int i = 1; i <= 4; i++) begin
            drive_step(1'b0, 0, '0, 1'b1, 0);
            n_vec++; if (bus.item_out !== WIDTH'(i)) begin n_fail++; $display("FAIL drain_item[%0d]: got %h want %h", i, bus.item_out, WIDTH'(i)); end
            n_vec++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b want %b", i, bus.valid_out, 1'b1); end
        end
        n_vec++; if (bus.empty[0] !== 1'b1) begin n_fail++; $display("FAIL drain_empty0: got %b want %b", bus.empty[0], 1'b1); end
        drive_step(1'b0, 0, '0, 1'b1, 0);
        n_vec++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL underrun_valid: got %b want %b", bus.valid_out, 1'b0); end
        n_vec++; if (bus.item_out !== 4'h4) begin n_fail++; $display("FAIL underrun_hold: got %h want %h", bus.item_out, 4'h4); end
`ifdef VC_FIFO_ERR_EN
        n_vec++; if (bus.underflow !== exp_udf) begin n_fail++; $display("FAIL underrun_udf: got %b want %b", bus.underflow, exp_udf); end
`endif
    endtask

    task automatic test_interleave();
        drive_step(1'b1, 0, 4'd7, 1'b0, 0);
        drive_step(1'b1, 1, 4'd5, 1'b1, 0);
        n_vec++; if (bus.item_out !== 4'd7) begin n_fail++; $display("FAIL inter_item: got %h want %h", bus.item_out, 4'd7); end
        n_vec++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL inter_valid: got %b want %b", bus.valid_out, 1'b1); end
        n_vec++; if (bus.empty !== 2'b01) begin n_fail++; $display("FAIL inter_empty: got %b want %b", bus.empty, 2'b01); end
        drive_step(1'b0, 0, '0, 1'b1, 1);
        n_vec++; if (bus.item_out !== 4'd5) begin n_fail++; $display("FAIL inter_vc1_head: got %h want %h", bus.item_out, 4'd5); end
        n_vec++; if (bus.empty !== 2'b11) begin n_fail++; $display("FAIL inter_empty2: got %b want %b", bus.empty, 2'b11); end
    endtask

    task automatic test_full_corner();
        for (int i = 8; i <= 11; i++) drive_step(1'b1, 1, WIDTH'(i), 1'b0, 0);
        n_vec++; if (bus.full !== 2'b10) begin n_fail++; $display("FAIL corner_full: got %b want %b", bus.full, 2'b10); end
        drive_step(1'b1, 1, 4'd12, 1'b1, 1);
        n_vec++; if (bus.item_out !== 4'd8) begin n_fail++; $display("FAIL corner_item: got %h want %h", bus.item_out, 4'd8); end
        n_vec++; if (bus.full !== 2'b00) begin n_fail++; $display("FAIL corner_full_clr: got %b want %b", bus.full, 2'b00); end
        n_vec++; if (bus.almost_full !== 2'b10) begin n_fail++; $display("FAIL corner_af: got %b want %b", bus.almost_full, 2'b10); end
`ifdef VC_FIFO_ERR_EN
        n_vec++; if (bus.overflow !== 2'b10) begin n_fail++; $display("FAIL corner_ovf: got %b want %b", bus.overflow, 2'b10); end
`endif
        drive_step(1'b1, 1, 4'd12, 1'b0, 0);
        n_vec++; if (bus.full !== 2'b10) begin n_fail++; $display("FAIL corner_refill: got %b want %b", bus.full, 2'b10); end
        for (int i = 9; i <= 12; i++) begin
            drive_step(1'b0, 0, '0, 1'b1, 1);
            n_vec++; if (bus.item_out !== WIDTH'(i)) begin n_fail++; $display("FAIL corner_order[%0d]: got %h want %h", i, bus.item_out, WIDTH'(i)); end
        end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) drive_step(1'b1, 0, WIDTH'(r * 4 + i), 1'b0, 0);
            for (int i = 0; i < 4; i++) begin
                drive_step(1'b0, 0, '0, 1'b1, 0);
                n_vec++; if (bus.item_out !== WIDTH'(r * 4 + i)) begin n_fail++; $display("FAIL wrap_order[%0d]: got %h want %h", r * 4 + i, bus.item_out, WIDTH'(r * 4 + i)); end
            end
            n_vec++; if (bus.empty !== 2'b11) begin n_fail++; $display("FAIL wrap_empty[%0d]: got %b want %b", r, bus.empty, 2'b11); end
        end
    endtask

    task automatic test_reset_midburst();
        drive_step(1'b1, 0, 4'd3, 1'b0, 0);
        drive_step(1'b1, 0, 4'd6, 1'b0, 0);
        drive_step(1'b1, 1, 4'd9, 1'b1, 0);
        n_vec++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want %b", bus.valid_out, 1'b1); end
        #1;
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        n_vec++; if (bus.empty !== 2'b11) begin n_fail++; $display("FAIL mid_empty: got %b want %b", bus.empty, 2'b11); end
        n_vec++; if (bus.full !== 2'b00) begin n_fail++; $display("FAIL mid_full: got %b want %b", bus.full, 2'b00); end
        n_vec++; if (bus.almost_full !== 2'b00) begin n_fail++; $display("FAIL mid_af: got %b want %b", bus.almost_full, 2'b00); end
        n_vec++; if (bus.item_out !== 4'h0) begin n_fail++; $display("FAIL mid_item: got %h want %h", bus.item_out, 4'h0); end
        n_vec++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want %b", bus.valid_out, 1'b0); end
        @(negedge clk);
        reset = 1'b0;
        drive_step(1'b0, 0, '0, 1'b1, 0);
        n_vec++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_post_valid: got %b want %b", bus.valid_out, 1'b0); end
`ifdef VC_FIFO_ERR_EN
        n_vec++; if (bus.underflow !== 2'b01) begin n_fail++; $display("FAIL mid_udf: got %b want %b", bus.underflow, 2'b01); end
        n_vec++; if (bus.overflow !== 2'b00) begin n_fail++; $display("FAIL mid_ovf: got %b want %b", bus.overflow, 2'b00); end
`endif
    endtask

    task automatic test_random();
        for (int s = 0; s < 400; s++) begin
            drive_step(1'b1 & ($urandom_range(0, 99) < 60), $urandom_range(0, NUM_VC - 1),
                       WIDTH'($urandom_range(0, 15)),
                       1'b1 & ($urandom_range(0, 99) < 50), $urandom_range(0, NUM_VC - 1));
            n_vec++; if (bus.valid_out !== exp_valid) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want %b", s, bus.valid_out, exp_valid); end
            n_vec++; if (bus.item_out !== exp_item) begin n_fail++; $display("FAIL rand_item[%0d]: got %h want %h", s, bus.item_out, exp_item); end
            n_vec++; if (bus.full !== exp_full()) begin n_fail++; $display("FAIL rand_full[%0d]: got %b want %b", s, bus.full, exp_full()); end
            n_vec++; if (bus.empty !== exp_empty()) begin n_fail++; $display("FAIL rand_empty[%0d]: got %b want %b", s, bus.empty, exp_empty()); end
            n_vec++; if (bus.almost_full !== exp_af()) begin n_fail++; $display("FAIL rand_af[%0d]: got %b want %b", s, bus.almost_full, exp_af()); end
`ifdef VC_FIFO_ERR_EN
            n_vec++; if (bus.overflow !== exp_ovf) begin n_fail++; $display("FAIL rand_ovf[%0d]: got %b want %b", s, bus.overflow, exp_ovf); end
            n_vec++; if (bus.underflow !== exp_udf) begin n_fail++; $display("FAIL rand_udf[%0d]: got %b want %b", s, bus.underflow, exp_udf); end
`endif
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill_vc0();
        test_drain_vc0();
        test_interleave();
        test_full_corner();
        test_wrap();
        test_reset_midburst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
